// File: rtl/frame_blit.sv
// Sprite blitter: streams a w x h sprite from ROM into the framebuffer at (x0, y0),
// clipping off-screen pixels and optionally skipping a transparent key colour.
module frame_blit #(
  parameter int FB_W   = 250,
  parameter int FB_H   = 200,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [9:0]        x0,
  input  logic [8:0]        y0,
  input  logic [7:0]        w,
  input  logic [7:0]        h,
  input  logic              key_en,
  input  logic [11:0]       key,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [11:0]       src_data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [10:0]       FB_W_X = 11'(FB_W);
  localparam logic [9:0]        FB_H_Y = 10'(FB_H);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(FB_W);

  state_t state_reg, state_next;

  logic [9:0]        x0_reg;
  logic [8:0]        y0_reg;
  logic [7:0]        w_reg, h_reg;
  logic              key_en_reg;
  logic [11:0]       key_reg;
  logic [7:0]        i_reg, j_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              pix_valid_reg;
  logic              clip_reg;
  logic [ADDR_W-1:0] fb_addr_reg;

  logic        accept;
  logic        row_end;
  logic        last_pix;
  logic [10:0] dx;
  logic [9:0]  dy;

  assign accept   = (state_reg == IDLE) && start && (w != 8'd0) && (h != 8'd0);
  assign row_end  = (i_reg == w_reg - 8'd1);
  assign last_pix = row_end && (j_reg == h_reg - 8'd1);
  // Widened sums so a sprite hanging off the right/bottom edge clips instead of wrapping.
  assign dx = {1'b0, x0_reg} + {3'b000, i_reg};
  assign dy = {1'b0, y0_reg} + {2'b00, j_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = ((w != 8'd0) && (h != 8'd0)) ? RUN : DONE;
      RUN:   if (last_pix) state_next = DRAIN;
      DRAIN: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_reg        <= '0;
      y0_reg        <= '0;
      w_reg         <= '0;
      h_reg         <= '0;
      key_en_reg    <= 1'b0;
      key_reg       <= '0;
      i_reg         <= '0;
      j_reg         <= '0;
      addr_reg      <= '0;
      pix_valid_reg <= 1'b0;
      clip_reg      <= 1'b0;
      fb_addr_reg   <= '0;
    end else begin
      pix_valid_reg <= (state_reg == RUN);
      if (accept) begin
        x0_reg     <= x0;
        y0_reg     <= y0;
        w_reg      <= w;
        h_reg      <= h;
        key_en_reg <= key_en;
        key_reg    <= key;
        i_reg      <= '0;
        j_reg      <= '0;
        addr_reg   <= '0;
      end else if (state_reg == RUN) begin
        // Raster order makes j*w+i a plain running increment.
        addr_reg <= addr_reg + 1'b1;
        if (row_end) begin
          i_reg <= '0;
          j_reg <= j_reg + 8'd1;
        end else begin
          i_reg <= i_reg + 8'd1;
        end
        clip_reg    <= (dx >= FB_W_X) || (dy >= FB_H_Y);
        fb_addr_reg <= ADDR_W'(dy) * STRIDE + ADDR_W'(dx);
      end
    end
  end

  // Write stage lines up with the ROM's one-cycle read latency.
  assign fb_we    = pix_valid_reg && !clip_reg && !(key_en_reg && (src_data == key_reg));
  assign fb_data  = pix_valid_reg ? src_data : 12'h000;
  assign fb_addr  = fb_addr_reg;
  assign src_addr = addr_reg;
  assign busy     = (state_reg == RUN) || (state_reg == DRAIN);
  assign done     = (state_reg == DONE);

endmodule
